// File: rtl/axi_write_adapter.sv
// Single-outstanding AXI3 write master for MEM-stage stores.
// Issues AW and W independently, collects B, holds completion until MEM takes it.
module axi_write_adapter (
    input  logic        clk,
    input  logic        reset,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic [3:0]  mem_sel,
    input  logic        mem_write_ready,
    output logic        mem_write_done,
    output logic [1:0]  mem_write_resp,
    output logic        mem_write_busy
);

    typedef enum logic [1:0] {StIdle, StAddrData, StWaitB, StDone} state_e;

    state_e      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  resp_q, resp_d;

    logic        aw_pending;
    logic        w_pending;
    logic [31:0] phys_addr;
    logic        unused_bid;

    assign unused_bid = ^bid;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto physical low memory.
    assign phys_addr = (mem_addr[31:29] == 3'b100 || mem_addr[31:29] == 3'b101) ?
                       {3'b000, mem_addr[28:0]} : mem_addr;

    assign aw_pending = awvalid_q && !awready;
    assign w_pending  = wvalid_q && !wready;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        resp_d    = resp_q;

        unique case (state_q)
            StIdle: begin
                if (mem_we) begin
                    if (mem_sel != 4'b0000) begin
                        awaddr_d  = phys_addr;
                        wdata_d   = mem_data;
                        wstrb_d   = mem_sel;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StAddrData;
                    end else begin
                        resp_d  = 2'b00;
                        state_d = StDone;
                    end
                end
            end
            StAddrData: begin
                awvalid_d = aw_pending;
                wvalid_d  = w_pending;
                if (!aw_pending && !w_pending) begin
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (bvalid) begin
                    resp_d  = bresp;
                    state_d = StDone;
                end
            end
            StDone: begin
                // mem_we is deliberately ignored here so a stalled MEM cannot re-issue.
                if (mem_write_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            resp_q    <= resp_d;
        end
    end

    assign awid    = 4'b0000;
    assign awlen   = 4'b0000;
    assign awsize  = 3'b010;
    assign awburst = 2'b00;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b001;
    assign wid     = 4'b0000;

    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign wlast   = wvalid_q;
    assign bready  = (state_q == StWaitB);

    assign mem_write_done = (state_q == StDone);
    assign mem_write_resp = resp_q;
    assign mem_write_busy = (state_q != StIdle);

endmodule
